// File: rtl/uart_pkg.sv
// Shared types and constants for the Wishbone UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   `ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
   `else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_t;
   `endif

   localparam logic [31:0] RXDATA_OFS = 32'h0;
   localparam logic [31:0] STATUS_OFS = 32'h4;

   localparam int ST_NE   = 0;
   localparam int ST_OVR  = 1;
   localparam int ST_FERR = 2;
   localparam int ST_FULL = 3;
   localparam int ST_PERR = 4;

   localparam int OVS      = 16;
   localparam int MID_TICK = 7;

   function automatic logic [31:0] pack_status(input logic ne, input logic ovr,
                                               input logic ferr, input logic full,
                                               input logic perr);
      logic [31:0] s;
      s          = '0;
      s[ST_NE]   = ne;
      s[ST_OVR]  = ovr;
      s[ST_FERR] = ferr;
      s[ST_FULL] = full;
      s[ST_PERR] = perr;
      return s;
   endfunction

endpackage

// File: rtl/wb_uart_rx_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push and pop together on a full FIFO
// both take effect, leaving the count unchanged.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
      $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wp, rp;
   logic             do_push, do_pop;

   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign dout    = mem[rp[AW-1:0]];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
      end
   end

endmodule

// File: rtl/wb_uart_rx.sv
// Wishbone UART receiver: 16x oversampled 8N1 deserialiser feeding an rx byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a PERR status flag.
module wb_uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 32_000_000,
   parameter int BAUD       = 1_000_000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic        CYC,
   input  logic        STB,
   input  logic        WE,
   input  logic [31:0] ADR,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        ACK,
   output logic        ERR,
   output logic        RTY,
   output logic        irq
);

   localparam int DIV = CLK_FREQ / (BAUD * OVS);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

   if (DIV < 1) begin : g_div_chk
      $error("wb_uart_rx: CLK_FREQ/(BAUD*16) must be at least 1");
   end

   logic          s1, s2, s3, rx_s, fall;
   logic [DW-1:0] dcnt;
   logic          tick;
   rx_state_t     state;
   logic [3:0]    tcnt;
   logic [2:0]    bitn;
   logic [7:0]    shreg;
   logic          push, ferr_set, perr_set;
   logic          pop_pend, pop;
   logic [7:0]    fifo_dout;
   logic          empty, full;
   logic          ovr, ferr, perr;
   logic          req, is_stat;
   logic          ovr_set, clr_ovr, clr_ferr;
   logic          unused_bits;

   assign RTY  = 1'b0;
   assign rx_s = s2;
   assign fall = s3 && !s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= rx;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dcnt <= '0;
         tick <= 1'b0;
      end else if (dcnt == DW'(DIV - 1)) begin
         dcnt <= '0;
         tick <= 1'b1;
      end else begin
         dcnt <= dcnt + 1'b1;
         tick <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tcnt     <= '0;
         bitn     <= '0;
         shreg    <= '0;
         push     <= 1'b0;
         ferr_set <= 1'b0;
         perr_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad  <= 1'b0;
`endif
      end else begin
         push     <= 1'b0;
         ferr_set <= 1'b0;
         perr_set <= 1'b0;
         case (state)
            IDLE: begin
               if (fall) begin
                  state <= START;
                  tcnt  <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (tcnt == 4'(MID_TICK)) begin
                     tcnt <= '0;
                     bitn <= '0;
                     state <= rx_s ? IDLE : DATA;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (tcnt == 4'(OVS - 1)) begin
                     tcnt  <= '0;
                     shreg <= {rx_s, shreg[7:1]};
                     if (bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        bitn <= bitn + 1'b1;
                     end
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (tcnt == 4'(OVS - 1)) begin
                     tcnt    <= '0;
                     par_bad <= rx_s ^ (^shreg);
                     state   <= STOP;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (tcnt == 4'(OVS - 1)) begin
                     tcnt     <= '0;
                     state    <= IDLE;
                     ferr_set <= !rx_s;
`ifdef UART_RX_PARITY_EN
                     perr_set <= par_bad;
                     push     <= rx_s && !par_bad;
`else
                     push     <= rx_s;
`endif
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (shreg),
      .dout  (fifo_dout),
      .empty (empty),
      .full  (full)
   );

   // The pop is registered from the request so it lands in the ACK cycle,
   // after DAT_O has already captured the head byte.
   assign pop      = pop_pend;
   assign is_stat  = (ADR[2] == STATUS_OFS[2]);
   assign req      = CYC && STB && !ACK && !ERR;
   assign ovr_set  = push && full && !pop;
   assign clr_ovr  = req && WE && is_stat && DAT_I[ST_OVR];
   assign clr_ferr = req && WE && is_stat && DAT_I[ST_FERR];

`ifdef UART_RX_PARITY_EN
   logic clr_perr;
   assign clr_perr = req && WE && is_stat && DAT_I[ST_PERR];

   always_ff @(posedge clk) begin
      if (rst) perr <= 1'b0;
      else     perr <= perr_set || (perr && !clr_perr);
   end
`else
   assign perr = 1'b0;
`endif

   assign unused_bits = ^{ADR[31:3], ADR[1:0], DAT_I[31:5], DAT_I[4], DAT_I[3],
                          DAT_I[0], RXDATA_OFS, perr_set};

   always_ff @(posedge clk) begin
      if (rst) begin
         ACK      <= 1'b0;
         ERR      <= 1'b0;
         DAT_O    <= '0;
         pop_pend <= 1'b0;
         irq      <= 1'b0;
         ovr      <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         ACK      <= 1'b0;
         ERR      <= 1'b0;
         DAT_O    <= '0;
         pop_pend <= 1'b0;
         irq      <= !empty;
         ovr      <= ovr_set || (ovr && !clr_ovr);
         ferr     <= ferr_set || (ferr && !clr_ferr);
         if (req) begin
            if (WE && !is_stat) begin
               ERR <= 1'b1;
            end else begin
               ACK <= 1'b1;
               if (!WE) begin
                  if (is_stat) begin
                     DAT_O <= pack_status(!empty, ovr, ferr, full, perr);
                  end else begin
                     DAT_O    <= {24'h0, empty ? 8'h00 : fifo_dout};
                     pop_pend <= !empty;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed bench for wb_uart_rx at DIV=2 (32 clocks per bit); honours UART_RX_PARITY_EN.
module tb_wb_uart_rx;

   logic        clk = 1'b0;
   logic        rst, rx, CYC, STB, WE;
   logic [31:0] ADR, DAT_I, DAT_O;
   logic        ACK, ERR, RTY, irq;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] wdat;
      logic [31:0] exp_dat;
      logic        exp_err;
   } vec_t;

   vec_t tbl[$];

   wb_uart_rx #(
      .CLK_FREQ   (32_000_000),
      .BAUD       (1_000_000),
      .FIFO_DEPTH (8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .rx    (rx),
      .CYC   (CYC),
      .STB   (STB),
      .WE    (WE),
      .ADR   (ADR),
      .DAT_I (DAT_I),
      .DAT_O (DAT_O),
      .ACK   (ACK),
      .ERR   (ERR),
      .RTY   (RTY),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop, input logic par);
      rx = 1'b0;
      cyc(32);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         cyc(32);
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      cyc(32);
`else
      if (par) rx = 1'b1;
`endif
      rx = stop;
      cyc(32);
      rx = 1'b1;
      cyc(4);
   endtask

   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic ack, output logic err);
      int n;
      CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; DAT_I = wd;
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (!ACK && !ERR && n < 8);
      rd  = DAT_O;
      ack = ACK;
      err = ERR;
      CYC = 1'b0; STB = 1'b0; WE = 1'b0; DAT_I = '0;
      check("bus_latency", 32'(n), 32'd1);
      cyc(1);
      check("dat_o_idle", DAT_O, 32'h0);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
      logic [31:0] rd;
      logic        a, e;
      xfer(1'b0, adr, '0, rd, a, e);
      check({name, "_ack"}, {31'h0, a}, 32'h1);
      check(name, rd, exp);
   endtask

   task automatic wr_stat(input logic [31:0] wd);
      logic [31:0] rd;
      logic        a, e;
      xfer(1'b1, 32'h4, wd, rd, a, e);
      check("w1c_ack", {31'h0, a}, 32'h1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        a, e;
      logic [31:0] got [8];
      int          acks, n;

      rst = 1'b1; rx = 1'b1; CYC = 1'b0; STB = 1'b0; WE = 1'b0;
      ADR = '0; DAT_I = '0;

      // Test 3 bus sequence after 9 back-to-back bytes into an 8-deep FIFO.
      tbl.push_back(vec_t'{we:1'b0, adr:32'h4, wdat:32'h0, exp_dat:32'hB,  exp_err:1'b0});
      for (int i = 1; i <= 8; i++)
         tbl.push_back(vec_t'{we:1'b0, adr:32'h0, wdat:32'h0, exp_dat:32'(i), exp_err:1'b0});
      tbl.push_back(vec_t'{we:1'b0, adr:32'h4, wdat:32'h0, exp_dat:32'h2,  exp_err:1'b0});
      tbl.push_back(vec_t'{we:1'b1, adr:32'h4, wdat:32'h2, exp_dat:32'h0,  exp_err:1'b0});
      tbl.push_back(vec_t'{we:1'b0, adr:32'h4, wdat:32'h0, exp_dat:32'h0,  exp_err:1'b0});
      tbl.push_back(vec_t'{we:1'b0, adr:32'h0, wdat:32'h0, exp_dat:32'h0,  exp_err:1'b0});
      tbl.push_back(vec_t'{we:1'b1, adr:32'h0, wdat:32'h77, exp_dat:32'h0, exp_err:1'b1});

      cyc(4);
      check("rst_dat_o", DAT_O, 32'h0);
      check("rst_ack", {31'h0, ACK}, 32'h0);
      check("rst_err", {31'h0, ERR}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("rst_rty", {31'h0, RTY}, 32'h0);
      rst = 1'b0;
      cyc(40);

      // 1: single byte
      send_byte(8'h55, 1'b1, ^8'h55);
      n = 0;
      while (!irq && n < 200) begin
         cyc(1);
         n++;
      end
      check("t1_irq", {31'h0, irq}, 32'h1);
      rd_chk("t1_stat_ne", 32'h4, 32'h9 & 32'h1);
      rd_chk("t1_data", 32'h0, 32'h55);
      rd_chk("t1_stat", 32'h4, 32'h0);
      check("t1_irq_low", {31'h0, irq}, 32'h0);

      // 2: short low glitch
      rx = 1'b0;
      cyc(10);
      rx = 1'b1;
      cyc(64);
      rd_chk("t2_stat", 32'h4, 32'h0);
      check("t2_irq", {31'h0, irq}, 32'h0);

      // 3: overflow, then the table
      for (int b = 1; b <= 9; b++) send_byte(8'(b), 1'b1, ^8'(b));
      cyc(8);
      check("t3_irq", {31'h0, irq}, 32'h1);
      foreach (tbl[i]) begin
         xfer(tbl[i].we, tbl[i].adr, tbl[i].wdat, rd, a, e);
         check($sformatf("tbl%0d_err", i), {31'h0, e}, {31'h0, tbl[i].exp_err});
         check($sformatf("tbl%0d_ack", i), {31'h0, a}, {31'h0, !tbl[i].exp_err});
         if (!tbl[i].we) check($sformatf("tbl%0d_dat", i), rd, tbl[i].exp_dat);
      end

      // 4: framing error
      send_byte(8'hA3, 1'b0, ^8'hA3);
      cyc(8);
      rd_chk("t4_stat", 32'h4, 32'h4);
      wr_stat(32'h4);
      rd_chk("t4_clr", 32'h4, 32'h0);

      // 5: STB held six cycles with two bytes queued
      send_byte(8'hC1, 1'b1, ^8'hC1);
      send_byte(8'hC2, 1'b1, ^8'hC2);
      cyc(8);
      CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = 32'h0;
      acks = 0;
      for (int c = 0; c < 6; c++) begin
         cyc(1);
         if (ACK && acks < 8) begin
            got[acks] = DAT_O;
            acks++;
         end
      end
      CYC = 1'b0; STB = 1'b0;
      cyc(2);
      check("t5_acks", 32'(acks), 32'd3);
      check("t5_d0", got[0], 32'hC1);
      check("t5_d1", got[1], 32'hC2);
      check("t5_d2", got[2], 32'h0);

      // 6: write to RXDATA errors without side effect; then reset mid-frame
      send_byte(8'h3C, 1'b1, ^8'h3C);
      cyc(8);
      xfer(1'b1, 32'h0, 32'hFF, rd, a, e);
      check("t6_err", {31'h0, e}, 32'h1);
      check("t6_ack", {31'h0, a}, 32'h0);
      rd_chk("t6_stat", 32'h4, 32'h1);
      rd_chk("t6_data", 32'h0, 32'h3C);
      rx = 1'b0;
      cyc(32);
      rx = 1'b0; cyc(32);
      rx = 1'b1; cyc(32);
      rx = 1'b1; cyc(12);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(64);
      rd_chk("t6_rst_stat", 32'h4, 32'h0);
      check("t6_rst_irq", {31'h0, irq}, 32'h0);
      send_byte(8'h5A, 1'b1, ^8'h5A);
      cyc(8);
      rd_chk("t6_after_rst", 32'h0, 32'h5A);

`ifdef UART_RX_PARITY_EN
      send_byte(8'h07, 1'b1, 1'b0);
      cyc(8);
      rd_chk("par_stat", 32'h4, 32'h10);
      wr_stat(32'h10);
      rd_chk("par_clr", 32'h4, 32'h0);
`else
      wr_stat(32'h10);
      rd_chk("nopar_stat", 32'h4, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
